// File: rtl/dino_pkg.sv
// dino_pkg: shared FSM encoding and gap-counter constants for the obstacle spawner.
package dino_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2, SPAWN = 2'd3} state_t;
    localparam int DELAY_W = 12;
    localparam logic [3:0] GAP_LSB_FILL = 4'b1111;
endpackage

// File: rtl/tick_down_counter.sv
// tick_down_counter: loadable down counter that steps on tick and stops at zero.
module tick_down_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         tick,
    input  logic         clear,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);
    assign zero = count == '0;
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (load) count <= load_val;
        else if (tick && !zero) count <= count - W'(1);
endmodule

// File: rtl/obstacle_spawner.sv
// obstacle_spawner: paces obstacle spawns with a random gap counted in frame ticks.
module obstacle_spawner
    import dino_pkg::*;
#(
    parameter int DELAY_W = dino_pkg::DELAY_W,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               tick,
    input  logic [3:0]         rnd,
    output logic               gen_en,
    output logic               spawn,
    output logic               obstacle_type,
    output logic [DELAY_W-1:0] delay_cnt,
    output logic [CNT_W-1:0]   spawn_count,
    output logic [1:0]         state
);
    state_t st, st_next;
    logic   zero;
    always_ff @(posedge clk or posedge reset)
        if (reset) st <= IDLE;
        else st <= st_next;
    // en low always wins, including over an expiring gap
    always_comb begin
        st_next = st;
        case (st)
            IDLE:  st_next = en ? LOAD : IDLE;
            LOAD:  st_next = en ? WAIT : IDLE;
            WAIT:  st_next = !en ? IDLE : (tick && zero) ? SPAWN : WAIT;
            SPAWN: st_next = en ? LOAD : IDLE;
        endcase
    end
    tick_down_counter #(.W(DELAY_W)) gap_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (st == LOAD && en),
        .tick     (st == WAIT && en && tick),
        .clear    (st != IDLE && !en),
        .load_val (DELAY_W'({rnd, GAP_LSB_FILL})),
        .count    (delay_cnt),
        .zero     (zero)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) obstacle_type <= 1'b0;
        else if (st == LOAD && en) obstacle_type <= rnd[0];
    always_ff @(posedge clk or posedge reset)
        if (reset) spawn_count <= '0;
        else if (st == SPAWN && spawn_count != '1) spawn_count <= spawn_count + CNT_W'(1);
    assign gen_en = st == LOAD;
    assign spawn  = st == SPAWN;
    assign state  = st;
endmodule

// File: doc/obstacle_spawner.md
OBSTACLE_SPAWNER -- requirements
Module: obstacle_spawner

Interface
REQ-001 SHALL expose parameter: DELAY_W, 12, width of spawn-gap counter (gap value formed as 0000xxxx1111).
REQ-002 SHALL expose parameter: CNT_W, 8, width of the saturating spawned-obstacle counter.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: en  in  1  game-running enable; low = spawner idle.
REQ-006 Port: tick  in  1  one-cycle frame-tick strobe; the gap counter advances only on tick.
REQ-007 Port: rnd  in  4  random nibble from the upstream random generator; rnd[3] connects to q7 and rnd[0] connects to q4.
REQ-008 Port: gen_en  out  1  one-cycle pulse requesting the generator to advance.
REQ-009 Port: spawn  out  1  one-cycle obstacle-spawn strobe.
REQ-010 Port: obstacle_type  out  1  type of current/next obstacle (0 cactus, 1 bird).
REQ-011 Port: delay_cnt  out  DELAY_W  live gap counter value.
REQ-012 Port: spawn_count  out  CNT_W  number of obstacles spawned since reset, saturating.
REQ-013 Port: state  out  2  FSM state encoding (IDLE=0, LOAD=1, WAIT=2, SPAWN=3).

Function
REQ-014 FSM SHALL have states IDLE, LOAD, WAIT and SPAWN; all outputs SHALL be Moore (derived from registered state only).
REQ-015 In IDLE with en=1, next state SHALL be LOAD; with en=0, the FSM SHALL remain in IDLE.
REQ-016 LOAD SHALL last exactly one cycle: delay_cnt <= {4'b0000, rnd, 4'b1111}, obstacle_type <= rnd[0], gen_en=1, then go to WAIT.
REQ-017 gen_en SHALL be 1 only in LOAD; rnd SHALL be sampled in the same cycle, before the generator advances.
REQ-018 In WAIT, each cycle with tick=1 and delay_cnt!=0 SHALL decrement delay_cnt by 1; cycles with tick=0 SHALL hold it.
REQ-019 In WAIT, tick=1 with delay_cnt==0 SHALL move to SPAWN; total ticks from LOAD to spawn = gap+1 (16..256).
REQ-020 SPAWN SHALL last one cycle with spawn=1, then go to LOAD if en=1, else IDLE.
REQ-021 spawn_count SHALL increment in SPAWN and saturate at 2^CNT_W-1 without wrapping.
REQ-022 en=0 in LOAD, WAIT or SPAWN SHALL force next state IDLE and clear delay_cnt; spawn_count and obstacle_type SHALL hold.
REQ-023 en falling in the same cycle that WAIT expires (tick=1, delay_cnt==0) SHALL go to IDLE with no spawn pulse; en low wins.
REQ-024 rnd=4'b0000 SHALL be legal and give the minimum gap of 15.
REQ-025 spawn and gen_en SHALL never be high in the same cycle.

Reset
REQ-026 reset=1 SHALL asynchronously force state=IDLE, delay_cnt=0, obstacle_type=0, spawn_count=0, spawn=0 and gen_en=0.
REQ-027 Reset asserted mid-WAIT or mid-SPAWN SHALL abort with no spawn pulse; after release with en=1, operation SHALL restart via LOAD.

Structure
REQ-028 Shared package dino_pkg SHALL hold the FSM state enum, DELAY_W and the fill constant GAP_LSB_FILL=4'b1111.
REQ-029 The gap counter SHALL be a sub-module, tick_down_counter (load, tick-enable, clear, zero flag), instantiated once.

Verification
REQ-030 rnd=4'b0101, en=1, tick every cycle -> gen_en pulse in LOAD, delay_cnt=0x05F, spawn 96 ticks after LOAD, obstacle_type=1.
REQ-031 rnd=4'b0000 -> gap 15, spawn after 16 ticks; rnd=4'b1111 -> gap 255, spawn after 256 ticks.
REQ-032 tick every 4th cycle, rnd=4'b0001 -> delay_cnt holds between ticks; spawn after 32 ticks (128 cycles).
REQ-033 Drop en on the cycle delay_cnt==0 with tick=1 -> no spawn, state=IDLE next cycle, delay_cnt=0.
REQ-034 Assert reset mid-WAIT -> all outputs zero immediately; re-enable -> LOAD, then normal spawn.
REQ-035 Force 300 spawns (CNT_W=8) -> spawn_count stops at 255 and spawns continue.
